// File: rtl/data_array_rd_ctrl.sv
// Read-side controller for the 40x128 data array R0 port: tagged requests in,
// fixed-latency capture, in-order tagged responses through a credit-protected queue.
module data_array_rd_ctrl #(
    parameter int unsigned ROWS  = 40,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 128,
    parameter int unsigned TW    = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [AW-1:0] i_req_addr,
    input  logic [TW-1:0] i_req_tag,
    output logic          o_resp_valid,
    input  logic          i_resp_ready,
    output logic [DW-1:0] o_resp_data,
    output logic [TW-1:0] o_resp_tag,
    output logic          o_resp_err,
    output logic [AW-1:0] o_mem_R0_addr,
    output logic          o_mem_R0_en,
    input  logic [DW-1:0] i_mem_R0_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic          r_reset_d;
    logic          r_cap_valid;
    logic [TW-1:0] r_cap_tag;
    logic          r_cap_err;

    logic [DW-1:0] r_q_data [DEPTH];
    logic [TW-1:0] r_q_tag  [DEPTH];
    logic          r_q_err  [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_in_range;
    logic          w_accept;
    logic          w_enq;
    logic          w_deq;
    logic          w_resp_valid;
    logic [CW-1:0] w_used;

    assign w_in_range = (32'(i_req_addr) < ROWS);

    // Credit counts the capture slot too, so the queue can never overflow.
    assign w_used      = r_count + {{(CW-1){1'b0}}, r_cap_valid};
    assign o_req_ready = !i_reset && !r_reset_d && (w_used < CW'(DEPTH));
    assign w_accept    = i_req_valid && o_req_ready;

    assign w_enq        = r_cap_valid && !i_reset;
    assign w_resp_valid = !i_reset && (r_count != '0);
    assign w_deq        = w_resp_valid && i_resp_ready;

    assign o_mem_R0_addr = i_req_addr;
    assign o_mem_R0_en   = !i_reset && ((w_accept && w_in_range) || (r_cap_valid && !r_cap_err));

    assign o_resp_valid = w_resp_valid;
    assign o_resp_data  = w_resp_valid ? r_q_data[r_rd_ptr] : '0;
    assign o_resp_tag   = w_resp_valid ? r_q_tag[r_rd_ptr] : '0;
    assign o_resp_err   = w_resp_valid ? r_q_err[r_rd_ptr] : 1'b0;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_reset_d   <= 1'b1;
            r_cap_valid <= 1'b0;
            r_cap_tag   <= '0;
            r_cap_err   <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_reset_d   <= 1'b0;
            r_cap_valid <= w_accept;
            r_cap_tag   <= i_req_tag;
            r_cap_err   <= !w_in_range;
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge i_clock) begin
        if (w_enq) begin
            r_q_data[r_wr_ptr] <= r_cap_err ? '0 : i_mem_R0_data;
            r_q_tag[r_wr_ptr]  <= r_cap_tag;
            r_q_err[r_wr_ptr]  <= r_cap_err;
        end
    end

    a_no_overflow : assert property (@(posedge i_clock) disable iff (i_reset)
        !(w_enq && (r_count == CW'(DEPTH))));

endmodule

// File: tb/tb_data_array_rd_ctrl.sv
// Self-checking bench for data_array_rd_ctrl with a behavioural array model and
// an in-order response scoreboard.
module tb_data_array_rd_ctrl;

    localparam int ROWS = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [5:0]   req_addr;
    logic [3:0]   req_tag;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_data;
    logic [3:0]   resp_tag;
    logic         resp_err;
    logic [5:0]   mem_addr;
    logic         mem_en;
    logic [127:0] mem_data;

    logic [127:0] mem [ROWS];
    logic [5:0]   arr_addr_q;

    typedef struct {
        logic [3:0]   tag;
        logic         err;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_resp   = 0;

    always #5 clk = ~clk;

    data_array_rd_ctrl u_dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_addr    (req_addr),
        .i_req_tag     (req_tag),
        .o_resp_valid  (resp_valid),
        .i_resp_ready  (resp_ready),
        .o_resp_data   (resp_data),
        .o_resp_tag    (resp_tag),
        .o_resp_err    (resp_err),
        .o_mem_R0_addr (mem_addr),
        .o_mem_R0_en   (mem_en),
        .i_mem_R0_data (mem_data)
    );

    // Array model: address registered on the edge, data valid only while enabled.
    always @(posedge clk) arr_addr_q <= mem_addr;
    assign mem_data = !mem_en ? {4{32'hDEAD_BEEF}} :
                      (arr_addr_q < 6'(ROWS)) ? mem[arr_addr_q] : {4{32'hBAD0_BAD0}};

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (resp_valid && resp_ready) begin
                n_checks++;
                n_resp++;
                if (sb.size() == 0) begin
                    $display("FAIL resp_unexpected: got tag=%0h err=%0b, no response expected",
                             resp_tag, resp_err);
                end else begin
                    e = sb.pop_front();
                    if ({resp_tag, resp_err, resp_data} !== {e.tag, e.err, e.data})
                        $display("FAIL resp_order: got tag=%0h err=%0b data=%h, want tag=%0h err=%0b data=%h",
                                 resp_tag, resp_err, resp_data, e.tag, e.err, e.data);
                    else
                        n_pass++;
                end
            end
            if (req_valid && req_ready) begin
                e.tag  = req_tag;
                e.err  = (req_addr >= 6'(ROWS));
                e.data = (req_addr < 6'(ROWS)) ? mem[req_addr] : '0;
                sb.push_back(e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; req_addr = '0; req_tag = '0;
        cyc();
        cyc();
        @(negedge clk);
        n_checks++;
        if ({req_ready, resp_valid, mem_en, resp_data, resp_tag, resp_err} !== '0)
            $display("FAIL reset_outputs: got ready=%0b valid=%0b en=%0b data=%h tag=%0h err=%0b, want all 0",
                     req_ready, resp_valid, mem_en, resp_data, resp_tag, resp_err);
        else n_pass++;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, resp_valid, mem_en} !== 3'b000)
            $display("FAIL post_reset_cycle: got ready=%0b valid=%0b en=%0b, want 0 0 0",
                     req_ready, resp_valid, mem_en);
        else n_pass++;
        cyc();
        @(negedge clk);
        n_checks++;
        if ({req_ready, resp_valid, mem_en} !== 3'b100)
            $display("FAIL idle_ready: got ready=%0b valid=%0b en=%0b, want 1 0 0",
                     req_ready, resp_valid, mem_en);
        else n_pass++;
        cyc();
    endtask

    task automatic test_single_read(input logic [5:0] addr, input logic [3:0] tag);
        logic         exp_en   = (addr < 6'(ROWS));
        logic [127:0] exp_data = exp_en ? mem[addr] : '0;
        req_valid = 1'b1; req_addr = addr; req_tag = tag;
        @(negedge clk);
        n_checks++;
        if ({req_ready, mem_en, mem_addr} !== {1'b1, exp_en, addr})
            $display("FAIL read_t0 addr=%0d: got ready=%0b en=%0b maddr=%0d, want 1 %0b %0d",
                     addr, req_ready, mem_en, mem_addr, exp_en, addr);
        else n_pass++;
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_en, resp_valid} !== {exp_en, 1'b0})
            $display("FAIL read_t1 addr=%0d: got en=%0b valid=%0b, want %0b 0",
                     addr, mem_en, resp_valid, exp_en);
        else n_pass++;
        cyc();
        @(negedge clk);
        n_checks++;
        if ({resp_valid, resp_tag, resp_err, resp_data} !== {1'b1, tag, !exp_en, exp_data})
            $display("FAIL read_t2 addr=%0d: got valid=%0b tag=%0h err=%0b data=%h, want 1 %0h %0b %h",
                     addr, resp_valid, resp_tag, resp_err, resp_data, tag, !exp_en, exp_data);
        else n_pass++;
        cyc();
        cyc();
        n_checks++;
        if (sb.size() != 0 || resp_valid !== 1'b0)
            $display("FAIL read_drain: got pending=%0d valid=%0b, want 0 0", sb.size(), resp_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int           acc = 0;
        int           t   = 0;
        logic         took;
        logic [3:0]   h_tag;
        logic [127:0] h_data;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 6'd10;
        req_tag    = 4'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            took = req_valid && req_ready;
            if (took) acc++;
            cyc();
            if (took) begin
                t++;
                req_addr = 6'(10 + t);
                req_tag  = 4'(t);
            end
        end
        @(negedge clk);
        n_checks++;
        if (acc != 4 || req_ready !== 1'b0)
            $display("FAIL bp_credit: got accepted=%0d ready=%0b, want 4 0", acc, req_ready);
        else n_pass++;
        h_tag  = resp_tag;
        h_data = resp_data;
        cyc();
        @(negedge clk);
        n_checks++;
        if ({resp_valid, resp_tag, resp_data} !== {1'b1, h_tag, h_data} || h_tag !== 4'd0)
            $display("FAIL bp_hold: got valid=%0b tag=%0h, want 1 held tag 0 (was %0h)",
                     resp_valid, resp_tag, h_tag);
        else n_pass++;
        cyc();
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b1)
                $display("FAIL bp_drain_gap beat %0d: got valid=%0b, want 1", i, resp_valid);
            else n_pass++;
            cyc();
        end
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0 || sb.size() != 0)
            $display("FAIL bp_drain_end: got valid=%0b pending=%0d, want 0 0", resp_valid, sb.size());
        else n_pass++;
        cyc();
    endtask

    task automatic test_stream();
        int stalls = 0;
        int enlow  = 0;
        int n0     = n_resp;
        resp_ready = 1'b1;
        for (int a = 0; a < ROWS; a++) begin
            req_valid = 1'b1;
            req_addr  = 6'(a);
            req_tag   = 4'(a);
            @(negedge clk);
            if (!req_ready) stalls++;
            if (!mem_en) enlow++;
            cyc();
        end
        req_valid = 1'b0;
        @(negedge clk);
        if (!mem_en) enlow++;
        cyc();
        n_checks++;
        if (stalls != 0 || enlow != 0)
            $display("FAIL stream_rate: got stalls=%0d en_low=%0d, want 0 0", stalls, enlow);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            cyc();
        end
        cyc();
        n_checks++;
        if (n_resp - n0 != ROWS || sb.size() != 0)
            $display("FAIL stream_count: got responses=%0d pending=%0d, want %0d 0",
                     n_resp - n0, sb.size(), ROWS);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1;
            req_addr  = 6'(20 + k);
            req_tag   = 4'(8 + k);
            cyc();
        end
        req_valid = 1'b0;
        rst       = 1'b1;
        sb.delete();
        @(negedge clk);
        n_checks++;
        if ({resp_valid, mem_en, req_ready} !== 3'b000)
            $display("FAIL mid_reset: got valid=%0b en=%0b ready=%0b, want 0 0 0",
                     resp_valid, mem_en, req_ready);
        else n_pass++;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({resp_valid, mem_en, req_ready} !== 3'b000)
            $display("FAIL mid_post_reset: got valid=%0b en=%0b ready=%0b, want 0 0 0",
                     resp_valid, mem_en, req_ready);
        else n_pass++;
        cyc();
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid || mem_en) stale++;
            cyc();
        end
        n_checks++;
        if (stale != 0 || req_ready !== 1'b1)
            $display("FAIL mid_stale: got stale_cycles=%0d ready=%0b, want 0 1", stale, req_ready);
        else n_pass++;
        test_single_read(6'd7, 4'd9);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < ROWS; r++) mem[r] = {4{32'hC0DE_0000 | 32'(r)}};
        mem[5] = {16{8'hA5}};
        test_reset();
        test_single_read(6'd5, 4'd3);
        test_single_read(6'd40, 4'd7);
        test_single_read(6'd63, 4'd1);
        test_single_read(6'd39, 4'd12);
        test_backpressure();
        test_stream();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
